// File: rtl/keypad_pkg.sv
// Shared definitions for the matrix keypad scanner: key codes, debounce
// state encoding, and the key map / digit-bus helper functions.
package keypad_pkg;

  // Reserved key codes beyond the digits 0-9
  localparam logic [3:0] KEY_NONE  = 4'hF;
  localparam logic [3:0] KEY_STAR  = 4'hA;
  localparam logic [3:0] KEY_HASH  = 4'hB;
  localparam logic [3:0] KEY_MULTI = 4'hE;

  // Column scan sequence, one column strobed low per state
  typedef enum logic [1:0] {
    SCAN_C0 = 2'd0,
    SCAN_C1 = 2'd1,
    SCAN_C2 = 2'd2
  } scan_state_e;

  // Debounce FSM: IDLE = stable none, CONFIRM = candidate differs from
  // stable and is being counted, HELD = stable key
  typedef enum logic [1:0] {
    DB_IDLE    = 2'd0,
    DB_CONFIRM = 2'd1,
    DB_HELD    = 2'd2
  } db_state_e;

  // Physical key at (row, column). Layout: 1 2 3 / 4 5 6 / 7 8 9 / * 0 #
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = KEY_NONE;
    case ({r, c})
      4'b00_00: code = 4'd1;
      4'b00_01: code = 4'd2;
      4'b00_10: code = 4'd3;
      4'b01_00: code = 4'd4;
      4'b01_01: code = 4'd5;
      4'b01_10: code = 4'd6;
      4'b10_00: code = 4'd7;
      4'b10_01: code = 4'd8;
      4'b10_10: code = 4'd9;
      4'b11_00: code = KEY_STAR;
      4'b11_01: code = 4'd0;
      4'b11_10: code = KEY_HASH;
      default:  code = KEY_NONE;
    endcase
    return code;
  endfunction

  // Active-low one-hot digit bus; non-digit codes leave every bit high
  function automatic logic [9:0] code_to_onehot_n(input logic [3:0] code);
    logic [9:0] v;
    v = 10'h3FF;
    for (int i = 0; i < 10; i++) begin
      if (code == 4'(i)) v[i] = 1'b0;
    end
    return v;
  endfunction

  // Column strobe pattern for a scan state: exactly one bit low
  function automatic logic [2:0] col_strobe(input scan_state_e s);
    logic [2:0] v;
    case (s)
      SCAN_C0: v = 3'b110;
      SCAN_C1: v = 3'b101;
      SCAN_C2: v = 3'b011;
      default: v = 3'b110;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debouncer. Each frame strobe delivers one frame result; a new
// value replaces the stable value only after DEBOUNCE_FRAMES consecutive
// identical frames. Multi-key frames count as "no key" (ghost rejection).
// Handshake: frame_strobe is a one-cycle valid with no back-pressure;
// frame_result is only meaningful while frame_strobe is high.
module keypad_debounce #(
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_strobe,
  input  logic [3:0] frame_result,
  output logic [3:0] stable,
  output logic       accept
);
  import keypad_pkg::*;

  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_FRAMES);

  db_state_e     state;
  logic [3:0]    cand;
  logic [CW-1:0] cnt;

  logic [3:0]    res;
  logic [3:0]    cand_n;
  logic [CW-1:0] cnt_n;
  logic          take;

  // Next candidate and run length for the frame being delivered
  always_comb begin
    res    = (frame_result == KEY_MULTI) ? KEY_NONE : frame_result;
    cand_n = cand;
    cnt_n  = cnt;
    if (res == cand) begin
      cnt_n = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    end else begin
      cand_n = res;
      cnt_n  = CW'(1);
    end
    take = (cand_n != stable) && (cnt_n == CNT_MAX);
  end

  // Debounce FSM; stable and accept update on the frame-end cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= DB_IDLE;
      cand   <= KEY_NONE;
      cnt    <= '0;
      stable <= KEY_NONE;
      accept <= 1'b0;
    end else begin
      accept <= 1'b0;
      if (frame_strobe) begin
        cand <= cand_n;
        cnt  <= cnt_n;
        case (state)
          DB_IDLE, DB_HELD: begin
            if (take) begin
              stable <= cand_n;
              accept <= (cand_n != KEY_NONE);
              state  <= (cand_n == KEY_NONE) ? DB_IDLE : DB_HELD;
            end else if (cand_n != stable) begin
              state <= DB_CONFIRM;
            end
          end
          DB_CONFIRM: begin
            if (take) begin
              stable <= cand_n;
              accept <= (cand_n != KEY_NONE);
              state  <= (cand_n == KEY_NONE) ? DB_IDLE : DB_HELD;
            end else if (cand_n == stable) begin
              state <= (stable == KEY_NONE) ? DB_IDLE : DB_HELD;
            end
          end
          default: state <= DB_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner. Strobes columns low one at a time, samples the
// synchronised rows at the end of each column dwell, assembles a per-frame
// result, debounces it and drives the digit bus and code/pulse outputs.
module keypad_scanner #(
  parameter int SCAN_DIV        = 1,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [2:0] col,
  output logic [9:0] keypad,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_press,
  output logic       star,
  output logic       hash
);
  import keypad_pkg::*;

  localparam int DW = $clog2(SCAN_DIV + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

  logic [3:0]    row_s1;
  logic [3:0]    row_s2;
  scan_state_e   scan_state;
  logic [DW-1:0] dwell;
  logic          last_dwell;

  // Sample tags travel alongside the synchroniser so each sample carries
  // the column it belongs to rather than the column currently strobed
  logic          tag1_v;
  logic [1:0]    tag1_col;
  logic          tag2_v;
  logic [1:0]    tag2_col;

  logic [3:0]    acc_code;
  logic          acc_multi;
  logic [3:0]    samp_low;
  logic [2:0]    samp_cnt;
  logic [1:0]    samp_row;
  logic [3:0]    nxt_code;
  logic          nxt_multi;
  logic          frame_strobe;
  logic [3:0]    frame_result;

  logic [3:0]    db_stable;
  logic          db_accept;

  assign last_dwell = (dwell == DWELL_LAST);

  // Two-flop synchroniser for the asynchronous row pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
    end else begin
      row_s1 <= row;
      row_s2 <= row_s1;
    end
  end

  // Column scan FSM: each column held SCAN_DIV cycles, c0 -> c1 -> c2 -> c0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_state <= SCAN_C0;
      dwell      <= '0;
      col        <= 3'b110;
    end else if (last_dwell) begin
      dwell <= '0;
      case (scan_state)
        SCAN_C0: begin
          scan_state <= SCAN_C1;
          col        <= col_strobe(SCAN_C1);
        end
        SCAN_C1: begin
          scan_state <= SCAN_C2;
          col        <= col_strobe(SCAN_C2);
        end
        default: begin
          scan_state <= SCAN_C0;
          col        <= col_strobe(SCAN_C0);
        end
      endcase
    end else begin
      dwell <= dwell + DW'(1);
    end
  end

  // Delay the "last dwell" marker by the two synchroniser stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag1_v   <= 1'b0;
      tag1_col <= 2'd0;
      tag2_v   <= 1'b0;
      tag2_col <= 2'd0;
    end else begin
      tag1_v   <= last_dwell;
      tag1_col <= scan_state;
      tag2_v   <= tag1_v;
      tag2_col <= tag1_col;
    end
  end

  // Fold the current column sample into the frame being assembled
  always_comb begin
    samp_low  = ~row_s2;
    samp_cnt  = 3'($countones(samp_low));
    samp_row  = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (samp_low[r]) samp_row = 2'(r);
    end
    // A column-0 sample always opens a fresh frame
    nxt_code  = (tag2_col == 2'd0) ? KEY_NONE : acc_code;
    nxt_multi = (tag2_col == 2'd0) ? 1'b0 : acc_multi;
    if (samp_cnt > 3'd1) begin
      nxt_multi = 1'b1;
    end else if (samp_cnt == 3'd1) begin
      if (nxt_code != KEY_NONE) nxt_multi = 1'b1;
      else                      nxt_code  = key_map(samp_row, tag2_col);
    end
    frame_strobe = tag2_v && (tag2_col == 2'd2);
    frame_result = nxt_multi ? KEY_MULTI : nxt_code;
  end

  // Frame accumulator holds partial results between column samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_code  <= KEY_NONE;
      acc_multi <= 1'b0;
    end else if (tag2_v) begin
      if (tag2_col == 2'd2) begin
        acc_code  <= KEY_NONE;
        acc_multi <= 1'b0;
      end else begin
        acc_code  <= nxt_code;
        acc_multi <= nxt_multi;
      end
    end
  end

  keypad_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_debounce (
    .clk          (clk),
    .rst          (rst),
    .frame_strobe (frame_strobe),
    .frame_result (frame_result),
    .stable       (db_stable),
    .accept       (db_accept)
  );

  // Registered outputs follow the debounced value one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keypad    <= 10'h3FF;
      key_code  <= KEY_NONE;
      key_valid <= 1'b0;
      key_press <= 1'b0;
      star      <= 1'b0;
      hash      <= 1'b0;
    end else begin
      keypad    <= code_to_onehot_n(db_stable);
      key_code  <= db_stable;
      key_valid <= (db_stable != KEY_NONE);
      key_press <= db_accept;
      star      <= (db_stable == KEY_STAR);
      hash      <= (db_stable == KEY_HASH);
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: two instances (SCAN_DIV=1 and SCAN_DIV=4) see the
// same simulated physical keypad; one is selected and checked at a time.
module tb_keypad_scanner;
  localparam int DF = 3;
  localparam logic [3:0] NONE = 4'hF;

  logic        clk;
  logic        rst;
  logic [11:0] keys;   // bit r*3+c set = key at (row r, column c) pressed
  logic        sel;

  logic [3:0] row_a, row_b;
  logic [2:0] col_a, col_b;
  logic [9:0] keypad_a, keypad_b;
  logic [3:0] code_a, code_b;
  logic valid_a, valid_b, press_a, press_b, star_a, star_b, hash_a, hash_b;

  logic [2:0] col_m;
  logic [9:0] keypad_m;
  logic [3:0] code_m;
  logic valid_m, press_m, star_m, hash_m;
  int scan_div_m;

  int n_tests = 0;
  int n_fail  = 0;
  int n_press = 0;
  logic [3:0] exp_q[$];
  logic [3:0] hist[$];
  logic [3:0] m_stable;
  bit at_frame_start;

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Physical keypad: a pressed key pulls its row low while its column is strobed
  function automatic logic [3:0] pins(input logic [11:0] k, input logic [2:0] c);
    logic [3:0] r;
    r = 4'hF;
    for (int i = 0; i < 12; i++) begin
      if (k[i] && !c[i % 3]) r[i / 3] = 1'b0;
    end
    return r;
  endfunction

  assign row_a = pins(keys, col_a);
  assign row_b = pins(keys, col_b);

  keypad_scanner #(.SCAN_DIV(1), .DEBOUNCE_FRAMES(DF)) u_dut1 (
    .clk(clk), .rst(rst), .row(row_a), .col(col_a), .keypad(keypad_a),
    .key_code(code_a), .key_valid(valid_a), .key_press(press_a),
    .star(star_a), .hash(hash_a));

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(DF)) u_dut4 (
    .clk(clk), .rst(rst), .row(row_b), .col(col_b), .keypad(keypad_b),
    .key_code(code_b), .key_valid(valid_b), .key_press(press_b),
    .star(star_b), .hash(hash_b));

  always_comb begin
    if (sel) begin
      col_m = col_b; keypad_m = keypad_b; code_m = code_b; valid_m = valid_b;
      press_m = press_b; star_m = star_b; hash_m = hash_b;
    end else begin
      col_m = col_a; keypad_m = keypad_a; code_m = code_a; valid_m = valid_a;
      press_m = press_a; star_m = star_a; hash_m = hash_a;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: key layout, frame rule, debounce as "last DF frames agree"
  function automatic logic [3:0] code_of(input int p);
    case (p)
      9:       return 4'hA;
      10:      return 4'h0;
      11:      return 4'hB;
      default: return 4'(p + 1);
    endcase
  endfunction

  function automatic logic [3:0] frame_res(input logic [11:0] k);
    if ($countones(k) != 1) return NONE;
    for (int i = 0; i < 12; i++) if (k[i]) return code_of(i);
    return NONE;
  endfunction

  function automatic logic [9:0] exp_onehot(input logic [3:0] c);
    if (c <= 4'd9) return 10'h3FF & ~(10'd1 << c);
    return 10'h3FF;
  endfunction

  function automatic logic [11:0] key_bit(input int i);
    return 12'd1 << i;
  endfunction

  task automatic model_frame(input logic [3:0] res);
    bit same;
    hist.push_back(res);
    if (hist.size() > DF) void'(hist.pop_front());
    if (hist.size() == DF) begin
      same = 1;
      foreach (hist[i]) if (hist[i] != hist[0]) same = 0;
      if (same && hist[0] != m_stable) begin
        m_stable = hist[0];
        exp_q.push_back(m_stable);
      end
    end
  endtask

  // Driver tasks
  task automatic wait_frame_start();
    logic [2:0] p;
    p = col_m;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (col_m == 3'b110 && p != 3'b110) return;
      p = col_m;
    end
    chk("frame_start_timeout", 0, 1);
  endtask

  task automatic drive_frame(input logic [11:0] k);
    if (!at_frame_start) wait_frame_start();
    at_frame_start = 0;
    keys = k;
    model_frame(frame_res(k));
  endtask

  task automatic hold(input logic [11:0] k, input int n);
    repeat (n) drive_frame(k);
  endtask

  task automatic settle();
    repeat (DF + 2) drive_frame(keys);
    chk("settle_pending", exp_q.size(), 0);
    chk("settle_code", code_m, m_stable);
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_col", col_m, 3'b110);
    chk("rst_keypad", keypad_m, 10'h3FF);
    chk("rst_code", code_m, NONE);
    chk("rst_valid", valid_m, 0);
    chk("rst_press", press_m, 0);
    chk("rst_star", star_m, 0);
    chk("rst_hash", hash_m, 0);
    hist.delete();
    exp_q.delete();
    m_stable = NONE;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    at_frame_start = 1;
  endtask

  // Scoreboard monitor: every debounced change must match the model's next one
  logic [3:0] prev_code;
  logic [2:0] prev_col;
  logic [3:0] e;
  int run_len;
  always @(negedge clk) begin
    if (rst) begin
      prev_code = NONE;
      prev_col  = 3'b110;
      run_len   = -1;
    end else begin
      if (col_m != prev_col) begin
        chk("col_one_low", $countones(col_m), 2);
        if (run_len >= 0) chk("col_dwell", run_len, scan_div_m);
        run_len  = 1;
        prev_col = col_m;
      end else if (run_len >= 0) begin
        run_len++;
      end
      if (press_m) n_press++;
      if (code_m != prev_code) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_change", code_m, prev_code);
        end else begin
          e = exp_q.pop_front();
          chk("key_code", code_m, e);
          chk("keypad", keypad_m, exp_onehot(e));
          chk("key_valid", valid_m, e != NONE);
          chk("star", star_m, e == 4'hA);
          chk("hash", hash_m, e == 4'hB);
          chk("key_press", press_m, e != NONE);
        end
        prev_code = code_m;
      end else if (press_m) begin
        chk("press_stray", press_m, 0);
      end
    end
  end

  task automatic run_suite();
    int p0;
    int a;
    int b;
    logic [11:0] k;
    do_reset(2);
    // Reset in the middle of a scan
    hold(key_bit(3), 1);
    do_reset($urandom_range(1, 4));

    // '5' press, long hold, release
    p0 = n_press;
    hold(key_bit(4), 3);
    hold(key_bit(4), 10);
    chk("held5_code", code_m, 4'd5);
    chk("held5_keypad", keypad_m, 10'h3DF);
    chk("held5_valid", valid_m, 1);
    hold(12'd0, 3);
    settle();
    chk("rel5_keypad", keypad_m, 10'h3FF);
    chk("press5_count", n_press - p0, 1);

    // Bounce: '7' for two frames only
    p0 = n_press;
    hold(key_bit(6), 2);
    hold(12'd0, 3);
    settle();
    chk("bounce_code", code_m, NONE);
    chk("bounce_press", n_press - p0, 0);

    // Ghost: '1'+'5' together, then '1' alone
    p0 = n_press;
    hold(key_bit(0) | key_bit(4), 5);
    chk("ghost_valid", valid_m, 0);
    chk("ghost_keypad", keypad_m, 10'h3FF);
    hold(key_bit(0), 3);
    settle();
    chk("ghost_code1", code_m, 4'd1);
    chk("ghost_keypad1", keypad_m, 10'h3FD);
    chk("ghost_press", n_press - p0, 1);
    hold(12'd0, 3);
    settle();

    // Direct change '2' -> '3'
    p0 = n_press;
    hold(key_bit(1), 3);
    settle();
    chk("chg_code2", code_m, 4'd2);
    chk("chg_keypad2", keypad_m, 10'h3FB);
    hold(key_bit(2), 3);
    settle();
    chk("chg_code3", code_m, 4'd3);
    chk("chg_keypad3", keypad_m, 10'h3F7);
    chk("chg_valid", valid_m, 1);
    chk("chg_press", n_press - p0, 2);

    // '*' then '#'
    p0 = n_press;
    hold(key_bit(9), 3);
    settle();
    chk("star_level", star_m, 1);
    chk("star_code", code_m, 4'hA);
    chk("star_keypad", keypad_m, 10'h3FF);
    hold(key_bit(11), 3);
    settle();
    chk("hash_level", hash_m, 1);
    chk("hash_star_off", star_m, 0);
    chk("hash_code", code_m, 4'hB);
    chk("starhash_press", n_press - p0, 2);
    hold(12'd0, 3);
    settle();
    chk("sh_release_hash", hash_m, 0);

    // Reset while confirming '9': count must restart
    hold(key_bit(8), 2);
    do_reset(3);
    p0 = n_press;
    hold(key_bit(8), 2);
    hold(12'd0, 3);
    settle();
    chk("midconfirm_code", code_m, NONE);
    chk("midconfirm_press", n_press - p0, 0);

    // Randomized key activity
    repeat (30) begin
      a = $urandom_range(0, 9);
      if (a < 2) begin
        k = 12'd0;
      end else if (a < 8) begin
        k = key_bit($urandom_range(0, 11));
      end else begin
        a = $urandom_range(0, 11);
        b = (a + $urandom_range(1, 11)) % 12;
        k = key_bit(a) | key_bit(b);
      end
      hold(k, $urandom_range(1, 5));
    end
    settle();
    hold(12'd0, 3);
    settle();
  endtask

  initial begin
    rst = 1'b1;
    keys = '0;
    sel = 1'b0;
    scan_div_m = 1;
    m_stable = NONE;
    at_frame_start = 0;
    run_suite();
    sel = 1'b1;
    scan_div_m = 4;
    run_suite();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
